// File: rtl/ne_layer_sched_ctrl_p26.sv
// ne_layer_sched_ctrl_p26: load/iteration/layer row sequencer with write-back delay line; define EARLY_TERM_EN for parity-based early termination
module ne_layer_sched_ctrl_p26 #(
  parameter int ROWDEPTH       = 20,
  parameter int ROWWIDTH       = 5,
  parameter int LAYERS         = 2,
  parameter int MAXITRS        = 10,
  parameter int ITRWIDTH       = 4,
  parameter int PIPESTAGES     = 13,
  parameter int PIPECOUNTWIDTH = 4,
  parameter int LOADDEPTH      = 17
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                loaden,
  input  logic                start,
`ifdef EARLY_TERM_EN
  input  logic                hd_parity_ok,
  output logic                early_term,
`endif
  output logic [4:0]          load_address,
  output logic                rd_en,
  output logic [ROWWIDTH-1:0] rd_address,
  output logic                rd_layer,
  output logic                rd_lastrow,
  output logic                wr_en,
  output logic [ROWWIDTH-1:0] wr_address,
  output logic                wr_layer,
  output logic [ITRWIDTH-1:0] itr,
  output logic                first_itr,
  output logic                busy,
  output logic                decoder_ready
);
  typedef enum logic [2:0] {IDLE, LOAD, READY, READ, DRAIN, DONE} state_t;
  localparam logic [4:0]                LOAD_LAST  = 5'(LOADDEPTH - 1);
  localparam logic [ROWWIDTH-1:0]       ROW_LAST   = ROWWIDTH'(ROWDEPTH - 1);
  localparam logic [PIPECOUNTWIDTH-1:0] DRAIN_LAST = PIPECOUNTWIDTH'(PIPESTAGES - 1);
  localparam logic [ITRWIDTH-1:0]       ITR_LAST   = ITRWIDTH'(MAXITRS - 1);
  localparam logic                      LAYER_LAST = 1'(LAYERS - 1);
  state_t                    state, nxt;
  logic [4:0]                load_cnt;
  logic [ROWWIDTH-1:0]       row;
  logic [PIPECOUNTWIDTH-1:0] dcnt;
  logic [ITRWIDTH-1:0]       itr_q;
  logic                      layer;
  logic [PIPESTAGES-1:0]     d_en, d_layer;
  logic [ROWWIDTH-1:0]       d_addr [PIPESTAGES];
  logic                      row_last, drain_last, layer_last, itr_last, et_hit;
  assign row_last   = row == ROW_LAST;
  assign drain_last = dcnt == DRAIN_LAST;
  assign layer_last = layer == LAYER_LAST;
  assign itr_last   = itr_q == ITR_LAST;
`ifdef EARLY_TERM_EN
  logic et_q;
  assign et_hit     = hd_parity_ok && !itr_last;
  assign early_term = et_q;
  always_ff @(posedge clk) begin
    if (rst) et_q <= 1'b0;
    else if (state == DRAIN && drain_last && layer_last && et_hit) et_q <= 1'b1;
    else if (state == DONE && loaden) et_q <= 1'b0;
  end
`else
  assign et_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = loaden ? LOAD : state;
      LOAD:       nxt = (loaden && load_cnt == LOAD_LAST) ? READY : LOAD;
      READY:      nxt = start ? READ : READY;
      READ:       nxt = row_last ? DRAIN : READ;
      DRAIN:      nxt = !drain_last ? DRAIN : (layer_last && (itr_last || et_hit)) ? DONE : READ;
      default:    nxt = IDLE;
    endcase
  end
  always_comb begin
    rd_en         = state == READ;
    busy          = state == READ || state == DRAIN;
    decoder_ready = state == DONE;
    first_itr     = busy && itr_q == '0;
    load_address  = load_cnt;
    rd_address    = row;
    rd_layer      = layer;
    rd_lastrow    = row == ROW_LAST;
    itr           = itr_q;
    wr_en         = d_en[PIPESTAGES-1];
    wr_address    = d_addr[PIPESTAGES-1];
    wr_layer      = d_layer[PIPESTAGES-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt <= '0;
      row      <= '0;
      dcnt     <= '0;
      itr_q    <= '0;
      layer    <= 1'b0;
    end else begin
      if ((state == IDLE || state == DONE) && loaden) load_cnt <= 5'd1;
      else if (state == LOAD && loaden && load_cnt != LOAD_LAST) load_cnt <= load_cnt + 5'd1;
      else if (state == READY && start) load_cnt <= '0;
      if (state == READ) row <= row_last ? '0 : row + 1'b1;
      if (state == DRAIN) dcnt <= drain_last ? '0 : dcnt + 1'b1;
      if (state == READY && start) begin
        itr_q <= '0;
        layer <= 1'b0;
      end else if (state == DRAIN && nxt == READ) begin
        layer <= layer_last ? 1'b0 : layer + 1'b1;
        itr_q <= layer_last ? itr_q + 1'b1 : itr_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      d_en    <= '0;
      d_layer <= '0;
      for (int i = 0; i < PIPESTAGES; i++) d_addr[i] <= '0;
    end else begin
      d_en      <= {d_en[PIPESTAGES-2:0], rd_en};
      d_layer   <= {d_layer[PIPESTAGES-2:0], rd_layer};
      d_addr[0] <= rd_address;
      for (int i = 1; i < PIPESTAGES; i++) d_addr[i] <= d_addr[i-1];
    end
  end
endmodule

// File: tb/tb_ne_layer_sched_ctrl_p26.sv
// tb_ne_layer_sched_ctrl_p26: randomized load/decode/abort sequences checked against a slot-arithmetic timing model
module tb_ne_layer_sched_ctrl_p26;
`ifdef EARLY_TERM_EN
  localparam bit ET = 1'b1;
  logic hd_parity_ok = 1'b0;
  logic early_term;
`else
  localparam bit ET = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, loaden = 1'b0, start = 1'b0;
  logic [4:0] load_address;
  logic rd_en, rd_layer, rd_lastrow, wr_en, wr_layer, first_itr, busy, decoder_ready;
  logic [4:0] rd_address, wr_address;
  logic [3:0] itr;
  int checks = 0, failures = 0;

  ne_layer_sched_ctrl_p26 dut (
    .clk(clk), .rst(rst), .loaden(loaden), .start(start),
`ifdef EARLY_TERM_EN
    .hd_parity_ok(hd_parity_ok), .early_term(early_term),
`endif
    .load_address(load_address), .rd_en(rd_en), .rd_address(rd_address), .rd_layer(rd_layer),
    .rd_lastrow(rd_lastrow), .wr_en(wr_en), .wr_address(wr_address), .wr_layer(wr_layer),
    .itr(itr), .first_itr(first_itr), .busy(busy), .decoder_ready(decoder_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_load_address"}, load_address, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_address"}, rd_address, 0);
    chk({tag, "_rd_layer"}, rd_layer, 0);
    chk({tag, "_rd_lastrow"}, rd_lastrow, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_address"}, wr_address, 0);
    chk({tag, "_wr_layer"}, wr_layer, 0);
    chk({tag, "_itr"}, itr, 0);
    chk({tag, "_first_itr"}, first_itr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_decoder_ready"}, decoder_ready, 0);
`ifdef EARLY_TERM_EN
    chk({tag, "_early_term"}, early_term, 0);
`endif
  endtask

  // 17 beats with random idle gaps and random (ignored) start pulses
  task automatic load_frame();
    for (int k = 0; k < 17; k++) begin
      chk("load_addr", load_address, k);
      loaden = 1'b1;
      start = 1'($urandom % 2);
      step();
      loaden = 1'b0;
      start = 1'b0;
      if (k == 0) begin
        chk("load_dr_clear", decoder_ready, 0);
`ifdef EARLY_TERM_EN
        chk("load_et_clear", early_term, 0);
`endif
      end
      if (k < 16) repeat ($urandom_range(0, 2)) begin
        start = 1'($urandom % 2);
        step();
        start = 1'b0;
        chk("load_hold_addr", load_address, k + 1);
        chk("load_busy", busy, 0);
      end
    end
    chk("ready_addr", load_address, 16);
    chk("ready_busy", busy, 0);
    chk("ready_rd_en", rd_en, 0);
  endtask

  // Expected behaviour from slot arithmetic: slot = 33 cycles, 20 reads then 13 drain
  task automatic run_decode(input int et_itr, input int abort_at);
    int end_t, slot, w, tw, e_itr, n_itr;
    bit act, e_rd, e_wr, e_et;
    n_itr = (ET && et_itr < 9) ? et_itr + 1 : 10;
    e_et = ET && et_itr < 9;
    end_t = n_itr * 66;
    repeat ($urandom_range(0, 3)) step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < end_t + 3; t++) begin
      slot = t / 33;
      w = t % 33;
      act = t < end_t;
      e_rd = act && w < 20;
      e_itr = slot / 2;
      tw = t - 13;
      e_wr = tw >= 0 && tw % 33 < 20 && tw < end_t;
      chk("rd_en", rd_en, e_rd);
      chk("rd_lastrow", rd_lastrow, e_rd && w == 19);
      chk("busy", busy, act);
      chk("decoder_ready", decoder_ready, !act);
      chk("first_itr", first_itr, act && e_itr == 0);
      chk("wr_en", wr_en, e_wr);
      if (e_rd) chk("rd_address", rd_address, w);
      if (act) begin
        chk("rd_layer", rd_layer, slot % 2);
        chk("itr", itr, e_itr);
      end
      if (e_wr) begin
        chk("wr_address", wr_address, tw % 33);
        chk("wr_layer", wr_layer, (tw / 33) % 2);
      end
`ifdef EARLY_TERM_EN
      chk("early_term", early_term, !act && e_et);
      hd_parity_ok = (t % 66 == 65) ? (t / 66 == et_itr) : 1'($urandom % 2);
`endif
      if (t == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero("abort");
        step();
        chk_zero("abort_idle");
        return;
      end
      start = 1'($urandom % 2);
      step();
    end
    start = 1'b0;
`ifdef EARLY_TERM_EN
    hd_parity_ok = 1'b0;
`endif
  endtask

  initial begin
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;
    step();
    chk_zero("idle");
    load_frame();
    loaden = 1'b1;
    step();
    loaden = 1'b0;
    chk("extra_beat_addr", load_address, 16);
    chk("extra_beat_busy", busy, 0);
    run_decode(99, -1);
    load_frame();
    run_decode(99, 3 * 66 + 7);
    load_frame();
    run_decode(99, -1);
`ifdef EARLY_TERM_EN
    load_frame();
    run_decode(2, -1);
    load_frame();
    run_decode(9, -1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
